// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: reaction-game sequencer with random arming delay, false-start/overflow detection and best-time tracking
module reaction_timer_ctrl #(
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  parameter int         MIN_DELAY_MS = 1000,
  parameter int         DELAY_SHIFT  = 2
) (
  input  logic        clock,
  input  logic        reset_button,
  input  logic        tick_1ms,
  input  logic        start_button,
  input  logic        stop_button,
  input  logic [15:0] digits_in,
  output logic        act,
  output logic        cnt_clear,
  output logic        led_go,
  output logic        false_start,
  output logic        timeout,
  output logic [2:0]  state_out,
  output logic [15:0] last_time,
  output logic [15:0] best_time,
  output logic        best_valid
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARM = 3'd1, GO = 3'd2, DONE = 3'd3, FALSE = 3'd4, TIMEOUT = 3'd5} state_t;
  state_t state_q, state_d;
  logic start_q, stop_q, cnt_clear_q, cnt_clear_d, best_valid_q, best_valid_d;
  logic st_edge, sp_edge, at_max;
  logic [7:0] lfsr_q, lfsr_d;
  logic [16:0] wait_q, wait_d;
  logic [15:0] last_q, last_d, best_q, best_d;
  assign st_edge = start_button & ~start_q;
  assign sp_edge = stop_button & ~stop_q;
  assign at_max = digits_in == 16'h9999;
  // right-shifting Galois form of x^8+x^6+x^5+x^4+1; maximal length, so never reaches zero
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  always_comb begin
    state_d = state_q;
    cnt_clear_d = 1'b0;
    wait_d = wait_q;
    last_d = last_q;
    best_d = best_q;
    best_valid_d = best_valid_q;
    act = 1'b0;
    case (state_q)
      IDLE, DONE, FALSE, TIMEOUT: if (st_edge) begin
        state_d = ARM;
        cnt_clear_d = 1'b1;
        wait_d = 17'(MIN_DELAY_MS) + (17'(lfsr_q) << DELAY_SHIFT);
      end
      ARM: if (sp_edge) state_d = FALSE;
        else if (tick_1ms) begin
          wait_d = wait_q - 17'd1;
          state_d = wait_q == 17'd1 ? GO : ARM;
        end
      GO: begin
        act = tick_1ms & ~sp_edge & ~at_max;
        if (sp_edge) begin
          state_d = DONE;
          last_d = digits_in;
          if (!best_valid_q || digits_in < best_q) begin
            best_d = digits_in;
            best_valid_d = 1'b1;
          end
        end else if (tick_1ms && at_max) state_d = TIMEOUT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset_button) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      stop_q <= 1'b1;
      cnt_clear_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
      wait_q <= '0;
      last_q <= 16'h0000;
      best_q <= 16'h9999;
      best_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_button;
      stop_q <= stop_button;
      cnt_clear_q <= cnt_clear_d;
      lfsr_q <= lfsr_d;
      wait_q <= wait_d;
      last_q <= last_d;
      best_q <= best_d;
      best_valid_q <= best_valid_d;
    end
  end
  assign cnt_clear = cnt_clear_q;
  assign led_go = state_q == GO;
  assign false_start = state_q == FALSE;
  assign timeout = state_q == TIMEOUT;
  assign state_out = state_q;
  assign last_time = last_q;
  assign best_time = best_q;
  assign best_valid = best_valid_q;
endmodule
